// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use and branch-flush logic
// plus an in-order scoreboard that tracks outstanding mul/div (MCU) results.
module hazard_scoreboard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RESETn,
  input  logic [REG_AW-1:0]         rs1D,
  input  logic [REG_AW-1:0]         rs2D,
  input  logic [REG_AW-1:0]         rdD,
  input  logic                      RegWriteD,
  input  logic                      mcuD,
  input  logic [REG_AW-1:0]         rs1E,
  input  logic [REG_AW-1:0]         rs2E,
  input  logic [REG_AW-1:0]         rdE,
  input  logic                      MemtoRegE,
  input  logic                      mcu_startE,
  input  logic [REG_AW-1:0]         rdM,
  input  logic [REG_AW-1:0]         rdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic [1:0]                PCSrcE,
  input  logic                      mcu_done,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [REG_AW-1:0]         mcu_rd,
  output logic                      mcu_busy,
  output logic                      sb_full,
  output logic [(1<<REG_AW)-1:0]    pending,
  output logic                      err
);

  localparam int unsigned NREG  = 1 << REG_AW;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [REG_AW-1:0] fifo [DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic [CNT_W-1:0]  count, cntNext;
  logic [NREG-1:0]   pendingNext;
  logic [NREG-1:0]   busyVec;
  logic              errQ, errNext;
  logic              doneAcc, startAcc, isEmpty, isFull;
  logic              lwStall, sbStall, fullStall, taken, hz;
  logic              unusedPcSrc;

  assign unusedPcSrc = PCSrcE[1];

  // M-stage result has priority over W-stage; x0 is never forwarded.
  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdMi,
    input logic              wrM,
    input logic [REG_AW-1:0] rdWi,
    input logic              wrW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wrM && (rdMi != '0) && (rs == rdMi))      sel = 2'b10;
    else if (wrW && (rdWi != '0) && (rs == rdWi)) sel = 2'b01;
    return sel;
  endfunction

  assign ForwardAE = fwdSel(rs1E, rdM, RegWriteM, rdW, RegWriteW);
  assign ForwardBE = fwdSel(rs2E, rdM, RegWriteM, rdW, RegWriteW);

  assign isEmpty  = (count == '0);
  assign isFull   = (count == CNT_W'(DEPTH));
  assign doneAcc  = mcu_done & ~isEmpty;
  // A same-cycle completion frees the slot before the new op is pushed.
  assign startAcc = mcu_startE & (~isFull | doneAcc);

  // Scoreboard next state: pop before push, set of pending wins over clear.
  always_comb begin
    cntNext     = count;
    wrPtrNext   = wrPtr;
    rdPtrNext   = rdPtr;
    pendingNext = pending;
    errNext     = errQ;
    if (doneAcc) begin
      cntNext             = cntNext - CNT_W'(1);
      rdPtrNext           = rdPtr + PTR_W'(1);
      pendingNext[mcu_rd] = 1'b0;
    end
    if (startAcc) begin
      cntNext   = cntNext + CNT_W'(1);
      wrPtrNext = wrPtr + PTR_W'(1);
      if (rdE != '0) pendingNext[rdE] = 1'b1;
    end
    if ((mcu_done && isEmpty) || (mcu_startE && isFull && !mcu_done)) errNext = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count   <= '0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      pending <= '0;
      errQ    <= 1'b0;
    end else begin
      count   <= cntNext;
      wrPtr   <= wrPtrNext;
      rdPtr   <= rdPtrNext;
      pending <= pendingNext;
      errQ    <= errNext;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (startAcc) begin
      fifo[wrPtr] <= rdE;
    end
  end

  assign mcu_rd   = fifo[rdPtr];
  assign mcu_busy = ~isEmpty;
  assign sb_full  = isFull;
  assign err      = errQ;

  // A register is busy while pending or while its producer issues this cycle.
  always_comb begin
    busyVec = pending;
    if (mcu_startE) busyVec[rdE] = 1'b1;
    busyVec[0] = 1'b0;
  end

  // Stall/flush resolution; a taken transfer cancels every Decode stall.
  always_comb begin
    lwStall   = MemtoRegE && (rdE != '0) && ((rs1D == rdE) || (rs2D == rdE));
    sbStall   = busyVec[rs1D] || busyVec[rs2D] || (RegWriteD && busyVec[rdD]);
    fullStall = mcuD && (cntNext == CNT_W'(DEPTH));
    taken     = PCSrcE[0];
    hz        = (lwStall || sbStall || fullStall) && !taken;
    StallF    = hz;
    StallD    = hz;
    FlushD    = taken;
    FlushE    = hz || taken;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_hazard_scoreboard;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NREG   = 1 << REG_AW;

  logic              CLK = 1'b0;
  logic              RESETn;
  logic [REG_AW-1:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW;
  logic              RegWriteD, mcuD, MemtoRegE, mcu_startE, RegWriteM, RegWriteW, mcu_done;
  logic [1:0]        PCSrcE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, FlushD, FlushE, mcu_busy, sb_full, err;
  logic [REG_AW-1:0] mcu_rd;
  logic [NREG-1:0]   pending;

  int unsigned errCount = 0;
  int unsigned checkCount = 0;

  // Reference model state
  int unsigned     q[$];
  bit [NREG-1:0]   pendM;
  bit              errM;

  hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .RegWriteD(RegWriteD), .mcuD(mcuD),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .MemtoRegE(MemtoRegE), .mcu_startE(mcu_startE),
    .rdM(rdM), .rdW(rdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .mcu_done(mcu_done),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .mcu_rd(mcu_rd), .mcu_busy(mcu_busy), .sb_full(sb_full), .pending(pending), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic setIdle();
    rs1D = 0; rs2D = 0; rdD = 0; RegWriteD = 0; mcuD = 0;
    rs1E = 0; rs2E = 0; rdE = 0; MemtoRegE = 0; mcu_startE = 0;
    rdM = 0; rdW = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 2'b00; mcu_done = 0;
  endtask

  function automatic logic [1:0] expFwd(input int unsigned rs);
    if (RegWriteM && rdM != 0 && rs == rdM) return 2'b10;
    if (RegWriteW && rdW != 0 && rs == rdW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit expBusy(input int unsigned r);
    return (r != 0) && (pendM[r] || (mcu_startE && rdE == r));
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic checkAll();
    bit doneOk, startOk, lw, sb, full, tk, hzM;
    int cntN;
    doneOk  = mcu_done && q.size() > 0;
    startOk = mcu_startE && (q.size() < DEPTH || doneOk);
    cntN    = q.size() + int'(startOk) - int'(doneOk);
    lw   = MemtoRegE && rdE != 0 && (rs1D == rdE || rs2D == rdE);
    sb   = expBusy(rs1D) || expBusy(rs2D) || (RegWriteD && expBusy(rdD));
    full = mcuD && cntN == DEPTH;
    tk   = PCSrcE[0];
    hzM  = (lw || sb || full) && !tk;
    checkEq("ForwardAE", 64'(ForwardAE), 64'(expFwd(rs1E)));
    checkEq("ForwardBE", 64'(ForwardBE), 64'(expFwd(rs2E)));
    checkEq("StallF", 64'(StallF), 64'(hzM));
    checkEq("StallD", 64'(StallD), 64'(hzM));
    checkEq("FlushD", 64'(FlushD), 64'(tk));
    checkEq("FlushE", 64'(FlushE), 64'(hzM || tk));
    checkEq("mcu_busy", 64'(mcu_busy), 64'(q.size() != 0));
    checkEq("sb_full", 64'(sb_full), 64'(q.size() == DEPTH));
    checkEq("pending", 64'(pending), 64'(pendM));
    checkEq("err", 64'(err), 64'(errM));
    if (q.size() > 0) checkEq("mcu_rd", 64'(mcu_rd), 64'(q[0]));
  endtask

  task automatic modelUpdate();
    bit doneOk, startOk;
    doneOk  = mcu_done && q.size() > 0;
    startOk = mcu_startE && (q.size() < DEPTH || doneOk);
    if ((mcu_done && q.size() == 0) || (mcu_startE && q.size() == DEPTH && !mcu_done)) errM = 1;
    if (doneOk) begin
      pendM[q[0]] = 1'b0;
      void'(q.pop_front());
    end
    if (startOk) begin
      q.push_back(int'(rdE));
      if (rdE != 0) pendM[rdE] = 1'b1;
    end
  endtask

  function automatic void modelReset();
    q.delete();
    pendM = '0;
    errM  = 0;
  endfunction

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    #1 checkAll();
    @(posedge CLK);
    modelUpdate();
    @(negedge CLK);
  endtask

  initial begin
    setIdle();
    modelReset();
    RESETn = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checkEq("rst_busy", 64'(mcu_busy), 64'd0);
    checkEq("rst_full", 64'(sb_full), 64'd0);
    checkEq("rst_rd", 64'(mcu_rd), 64'd0);
    checkEq("rst_pending", 64'(pending), 64'd0);
    checkEq("rst_err", 64'(err), 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;

    // Forwarding priority
    rs1E = 3; rdM = 3; rdW = 3; RegWriteM = 1; RegWriteW = 1;
    #1 checkEq("fwd_M", 64'(ForwardAE), 64'd2);
    RegWriteM = 0;
    #1 checkEq("fwd_W", 64'(ForwardAE), 64'd1);
    RegWriteM = 1; rs1E = 0; rdM = 0; rdW = 0;
    #1 checkEq("fwd_x0", 64'(ForwardAE), 64'd0);
    tick();

    // Branch overrides load-use stall
    setIdle(); MemtoRegE = 1; rdE = 3; rs1D = 3; PCSrcE = 2'b01;
    #1;
    checkEq("br_FlushD", 64'(FlushD), 64'd1);
    checkEq("br_FlushE", 64'(FlushE), 64'd1);
    checkEq("br_StallF", 64'(StallF), 64'd0);
    checkEq("br_StallD", 64'(StallD), 64'd0);
    tick();

    // RAW on MCU result, released the cycle after completion
    setIdle(); mcu_startE = 1; rdE = 5; rs1D = 5;
    #1;
    checkEq("raw_c0_stall", 64'(StallD), 64'd1);
    checkEq("raw_c0_flushE", 64'(FlushE), 64'd1);
    tick();
    mcu_startE = 0; rdE = 0;
    for (int c = 1; c <= 9; c++) begin
      #1;
      checkEq("raw_hold_pend", 64'(pending[5]), 64'd1);
      checkEq("raw_hold_stall", 64'(StallD), 64'd1);
      tick();
    end
    mcu_done = 1;
    #1;
    checkEq("raw_c10_rd", 64'(mcu_rd), 64'd5);
    checkEq("raw_c10_stall", 64'(StallD), 64'd1);
    tick();
    mcu_done = 0;
    #1 checkEq("raw_c11_stall", 64'(StallD), 64'd0);
    tick();

    // Fill to DEPTH, then drain in issue order
    setIdle();
    for (int i = 1; i <= 4; i++) begin
      mcu_startE = 1; rdE = REG_AW'(i);
      tick();
    end
    setIdle(); mcuD = 1; rs1D = 10; rs2D = 11;
    #1;
    checkEq("fill_full", 64'(sb_full), 64'd1);
    checkEq("fill_stall", 64'(StallD), 64'd1);
    tick();
    setIdle(); mcu_done = 1;
    for (int i = 1; i <= 4; i++) begin
      #1 checkEq("fill_order", 64'(mcu_rd), 64'(i));
      tick();
    end
    mcu_done = 0;
    #1 checkEq("fill_empty", 64'(mcu_busy), 64'd0);
    tick();

    // WAW against a pending destination
    setIdle(); mcu_startE = 1; rdE = 7;
    tick();
    setIdle(); RegWriteD = 1; rdD = 7; rs1D = 1; rs2D = 2;
    #1 checkEq("waw_stall", 64'(StallD), 64'd1);
    rdD = 0;
    #1 checkEq("waw_x0", 64'(StallD), 64'd0);
    tick();
    setIdle(); mcu_done = 1;
    tick();

    // Asynchronous reset with three ops outstanding
    setIdle(); mcu_startE = 1;
    for (int i = 0; i < 3; i++) begin
      rdE = REG_AW'(5 + i);
      tick();
    end
    setIdle();
    #2 RESETn = 1'b0;
    #1;
    modelReset();
    checkEq("arst_pending", 64'(pending), 64'd0);
    checkEq("arst_busy", 64'(mcu_busy), 64'd0);
    checkEq("arst_err", 64'(err), 64'd0);
    rs1D = 5;
    #1 checkEq("arst_stall", 64'(StallD), 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;

    // Completion with nothing outstanding is an error and is sticky
    setIdle(); mcu_done = 1;
    tick();
    mcu_done = 0;
    #1;
    checkEq("err_set", 64'(err), 64'd1);
    checkEq("err_cnt", 64'(mcu_busy), 64'd0);
    mcu_startE = 1; rdE = 4;
    tick();
    mcu_startE = 0; mcu_done = 1;
    tick();
    mcu_done = 0;
    #1 checkEq("err_sticky", 64'(err), 64'd1);
    tick();

    // Randomized traffic, alternating fill-biased and drain-biased phases
    @(negedge CLK);
    RESETn = 1'b0;
    #1 modelReset();
    @(negedge CLK);
    RESETn = 1'b1;
    for (int n = 0; n < 600; n++) begin
      int startPct, donePct;
      startPct = ((n / 50) % 2 == 0) ? 65 : 25;
      donePct  = ((n / 50) % 2 == 0) ? 30 : 60;
      rs1D = REG_AW'($urandom_range(0, 7)); rs2D = REG_AW'($urandom_range(0, 7));
      rdD  = REG_AW'($urandom_range(0, 7));
      RegWriteD = 1'($urandom_range(0, 1)); mcuD = 1'($urandom_range(0, 1));
      rs1E = REG_AW'($urandom_range(0, 7)); rs2E = REG_AW'($urandom_range(0, 7));
      rdE  = REG_AW'($urandom_range(0, 7));
      MemtoRegE = ($urandom_range(0, 99) < 25);
      mcu_startE = ($urandom_range(0, 99) < startPct);
      mcu_done   = ($urandom_range(0, 99) < donePct);
      rdM = REG_AW'($urandom_range(0, 7)); rdW = REG_AW'($urandom_range(0, 7));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      PCSrcE = ($urandom_range(0, 99) < 20) ? 2'b01 : 2'($urandom_range(0, 1) << 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the 5-stage Mach-V pipeline that adds a scoreboard for a variable-latency multi-cycle unit (MCU: mul/div) to the existing forwarding, load-use and branch-flush logic. Tracks up to DEPTH in-flight MCU ops in issue order and holds a per-register pending bitmap. Stalls Decode on RAW/WAW conflicts with pending MCU results or on scoreboard full. Taken branches override all Decode stalls.

## Interface
- REG_AW, 5, register address width; register count = 2^REG_AW.
- DEPTH, 4, max outstanding MCU ops; power of two, >= 2.

- CLK  in  1  clock, rising edge.
- RESETn  in  1  reset, asynchronous, active-low.
- rs1D, rs2D, rdD  in  REG_AW  Decode sources/destination.
- RegWriteD  in  1  Decode instruction writes rdD.
- mcuD  in  1  Decode instruction is an MCU op.
- rs1E, rs2E, rdE  in  REG_AW  Execute sources/destination.
- MemtoRegE  in  1  Execute instruction is a load.
- mcu_startE  in  1  Execute holds an MCU op that issues this cycle.
- rdM, rdW  in  REG_AW; RegWriteM, RegWriteW  in  1.
- PCSrcE  in  2  bit0 = control transfer taken in Execute.
- mcu_done  in  1  MCU completes its oldest op this cycle.
- ForwardAE, ForwardBE  out  2  10 = from M, 01 = from W, 00 = none.
- StallF, StallD, FlushD, FlushE  out  1.
- mcu_rd  out  REG_AW  destination of oldest op (FIFO head); MCU writes it when mcu_done.
- mcu_busy  out  1  count != 0.
- sb_full  out  1  count == DEPTH.
- pending  out  2^REG_AW  pending bitmap, debug.
- err  out  1  sticky protocol error.

## Operation
- Forwarding, per operand X in {1,2}: rsXE==rdM & RegWriteM & rdM!=0 -> 10; else rsXE==rdW & RegWriteW & rdW!=0 -> 01; else 00. M has priority over W.
- busy(r) = r!=0 & (pending[r] | (mcu_startE & rdE==r)).
- lwStall = MemtoRegE & rdE!=0 & (rs1D==rdE | rs2D==rdE).
- sbStall = busy(rs1D) | busy(rs2D) | (RegWriteD & busy(rdD)).
- cnt_next = count + mcu_startE_acc - mcu_done_acc, where acc denotes an accepted event (see errors).
- fullStall = mcuD & cnt_next == DEPTH.
- taken = PCSrcE[0]; hz = (lwStall | sbStall | fullStall) & ~taken.
- StallF = StallD = hz; FlushD = taken; FlushE = hz | taken.
- FIFO of rd tags: wr_ptr, rd_ptr (log2 DEPTH, wrap modulo DEPTH), count (0..DEPTH).
  - Push on accepted start: fifo[wr_ptr] <= rdE. Tag is pushed even when rdE==0.
  - Pop on accepted done.
- pending: clear pending[mcu_rd] on accepted done. Set pending[rdE] on accepted start if rdE!=0. Set wins if both target the same register.
- Start and done in the same cycle: pop then push, so this is allowed at count==DEPTH and count is unchanged.
- Errors (err sticky until reset):
  - done with count==0 is ignored.
  - start with count==DEPTH and no done is ignored.

## Timing
- All stall/flush/forward outputs are combinational from current inputs and registered state.
- pending, count and pointers update on the rising CLK edge.
- Completion cycle: the register is still pending and a dependent Decode op still stalls. It is released the cycle after mcu_done, when the register file already holds the result. There is no MCU result bypass.
- An issue in E blocks a dependent D op in the same cycle via the mcu_startE term.
- mcu_rd is valid in any cycle with count!=0.
- Reset (asynchronous, any cycle, including mid-operation):
  - pending=0, count=0, pointers=0, FIFO storage=0, err=0.
  - Hence mcu_busy=0, sb_full=0, mcu_rd=0.
  - Combinational outputs follow their inputs.

## Test plan
- Reset mid-operation: 3 ops outstanding, pulse RESETn low asynchronously -> pending=0, mcu_busy=0, err=0 immediately. rs1D=5 with no other hazard -> StallD=0.
- RAW on MCU result:
  - Cycle 0: mcu_startE, rdE=5, rs1D=5 -> StallD=1, FlushE=1.
  - Cycles 1-9: pending[5]=1, stall held.
  - Cycle 10: mcu_done -> mcu_rd=5, StallD=1.
  - Cycle 11: StallD=0.
- Fill and order, DEPTH=4: issue rd 1,2,3,4 -> sb_full=1; mcuD=1 -> StallD=1. Four dones -> mcu_rd 1,2,3,4 in order; count=0.
- WAW: pending[7]=1, RegWriteD=1, rdD=7, sources unrelated -> StallD=1. rdD=0 -> StallD=0.
- Branch override: lwStall condition (MemtoRegE, rdE=3, rs1D=3) with PCSrcE=01 -> FlushD=1, FlushE=1, StallF=0, StallD=0.
- Forwarding:
  - rs1E=rdM=rdW=3, RegWriteM=RegWriteW=1 -> ForwardAE=10.
  - RegWriteM=0 -> ForwardAE=01.
  - rs1E=rdM=rdW=0 -> ForwardAE=00.
- Error: mcu_done with count=0 -> err=1; count stays 0; err remains 1 through later normal traffic.
